// File: rtl/seq_decoder_n.sv
// Registered N-to-2^N decoder with valid/ready select input and four modes:
// one-hot decode, thermometer decode, auto-scan (walking one) and hold.
module seq_decoder_n #(
  parameter  int SEL_W    = 3,
  parameter  int SCAN_DIV = 4,
  localparam int OUT_W    = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_valid,
  output logic             sel_ready,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  output logic [SEL_W-1:0] scan_idx
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DEC,
    ST_SCAN,
    ST_HOLD
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] div_cnt, cnt_next;
  logic [SEL_W-1:0] idx_next, idx_inc;
  logic [OUT_W-1:0] y_next;
  logic             y_valid_next;
  logic             accept;
  logic [OUT_W:0]   therm_wide;

  assign sel_ready = en & ~mode[1];
  assign accept    = sel_valid & sel_ready;
  // Index wraps OUT_W-1 -> 0 naturally because OUT_W is exactly 2**SEL_W.
  assign idx_inc   = scan_idx + SEL_W'(1);
  // Bits 0..sel set; one extra bit so sel = OUT_W-1 does not overflow before truncation.
  assign therm_wide = ((OUT_W + 1)'(2) << sel) - (OUT_W + 1)'(1);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = ST_OFF;
    y_next       = y;
    y_valid_next = 1'b0;
    idx_next     = scan_idx;
    cnt_next     = div_cnt;

    if (en) begin
      unique case (mode)
        2'b10:   state_next = ST_SCAN;
        2'b11:   state_next = ST_HOLD;
        default: state_next = ST_DEC;
      endcase
    end

    unique case (state_next)
      ST_OFF: begin
        y_next   = '0;
        idx_next = '0;
        cnt_next = '0;
      end
      ST_DEC: begin
        if (accept) begin
          y_next       = mode[0] ? therm_wide[OUT_W-1:0] : (OUT_W'(1) << sel);
          y_valid_next = 1'b1;
        end
      end
      ST_SCAN: begin
        if (state != ST_SCAN) begin
          idx_next     = '0;
          cnt_next     = '0;
          y_next       = OUT_W'(1);
          y_valid_next = 1'b1;
        end else if (div_cnt == CNT_LAST) begin
          cnt_next     = '0;
          idx_next     = idx_inc;
          y_next       = OUT_W'(1) << idx_inc;
          y_valid_next = 1'b1;
        end else begin
          cnt_next = div_cnt + CNT_W'(1);
        end
      end
      default: ;  // ST_HOLD: everything frozen, y_valid stays low
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_OFF;
      y        <= '0;
      y_valid  <= 1'b0;
      scan_idx <= '0;
      div_cnt  <= '0;
    end else begin
      state    <= state_next;
      y        <= y_next;
      y_valid  <= y_valid_next;
      scan_idx <= idx_next;
      div_cnt  <= cnt_next;
    end
  end

endmodule
